// File: rtl/out_port_fifo_if.sv
// Handshake bundle for the buffered OUT port: the producer/consumer side is the
// master, the FIFO itself is the slave.
interface out_port_fifo_if #(
  parameter int Width = 16,
  parameter int Depth = 4
);
  localparam int LvlW = $clog2(Depth + 1);

  logic             write_enable;
  logic [Width-1:0] write_data;
  logic             clear_overflow;
  logic [Width-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] read_data;
  logic             full;
  logic             empty;
  logic [LvlW-1:0]  level;
  logic             overflow;

  modport master (
    output write_enable, write_data, clear_overflow, out_ready,
    input  out_data, out_valid, read_data, full, empty, level, overflow
  );

  modport slave (
    input  write_enable, write_data, clear_overflow, out_ready,
    output out_data, out_valid, read_data, full, empty, level, overflow
  );
endinterface

// File: rtl/out_port_fifo.sv
// Buffered output port: first-word-fall-through queue between the write-back
// stage and a slow consumer. State advances on the falling clock edge. A
// mirror register holds the last accepted word, and writes arriving while
// the queue is full (with no pop in the same cycle) are dropped and flagged
// in a sticky overflow bit.
module out_port_fifo #(
  parameter int Width = 16,
  parameter int Depth = 4
) (
  input  logic           clk,
  input  logic           reset,
  out_port_fifo_if.slave bus
);
  localparam int LvlW = $clog2(Depth + 1);
  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [Width-1:0] read_data_q, read_data_d;
  logic             overflow_q, overflow_d;

  logic empty_s, full_s, pop_s, push_s, drop_s;

  // Status flags come from the registered level only; pointers alone cannot
  // tell full from empty.
  assign empty_s = (level_q == LvlW'(0));
  assign full_s  = (level_q == LvlW'(Depth));

  // A pop needs a valid head; a full queue still accepts a write when the
  // head leaves in the same cycle.
  assign pop_s  = !empty_s & bus.out_ready;
  assign push_s = bus.write_enable & (!full_s | pop_s);
  assign drop_s = bus.write_enable & full_s & !pop_s;

  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.out_valid = !empty_s;
  assign bus.empty     = empty_s;
  assign bus.full      = full_s;
  assign bus.level     = level_q;
  assign bus.read_data = read_data_q;
  assign bus.overflow  = overflow_q;

  // Next-state for pointers, level, mirror and sticky overflow.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    read_data_d = read_data_q;
    overflow_d  = overflow_q;

    if (push_s) begin
      wr_ptr_d    = wr_ptr_q + PtrW'(1);
      read_data_d = bus.write_data;
    end else begin
      wr_ptr_d    = wr_ptr_q;
      read_data_d = read_data_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as a clear request keeps the flag set.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state register, falling-edge clocked with async reset.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= PtrW'(0);
      rd_ptr_q    <= PtrW'(0);
      level_q     <= LvlW'(0);
      read_data_q <= Width'(0);
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      read_data_q <= read_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage array; contents are don't-care after reset so it is not cleared.
  always_ff @(negedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.write_data;
    end
  end
endmodule

// File: tb/tb_out_port_fifo.sv
// Randomized plus directed bench for out_port_fifo, checked against a queue
// based reference model of the port behaviour.
module tb_out_port_fifo;
  localparam int W = 16;
  localparam int D = 4;

  logic clk;
  logic reset;

  out_port_fifo_if #(.Width(W), .Depth(D)) bus ();

  out_port_fifo #(.Width(W), .Depth(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state.
  logic [W-1:0] mdl_q[$];
  logic [W-1:0] mdl_mirror;
  logic         mdl_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    chk_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, 32'(bus.level), 32'(mdl_q.size()));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(mdl_q.size() == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(mdl_q.size() == D));
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'(mdl_q.size() != 0));
    chk({tag, ".rdata"}, 32'(bus.read_data), 32'(mdl_mirror));
    chk({tag, ".ovf"}, 32'(bus.overflow), 32'(mdl_ovf));
    if (mdl_q.size() != 0) chk({tag, ".odata"}, 32'(bus.out_data), 32'(mdl_q[0]));
  endtask

  // Called just after a rising edge: apply inputs, advance the model by the
  // rules of one falling edge, then check at the next rising edge.
  task automatic cycle(input logic we, input logic [W-1:0] wd, input logic rdy,
                       input logic clr, input string tag);
    bit pop, push, drop, was_full;
    bus.write_enable   = we;
    bus.write_data     = wd;
    bus.out_ready      = rdy;
    bus.clear_overflow = clr;
    was_full = (mdl_q.size() == D);
    pop  = rdy && (mdl_q.size() != 0);
    push = we && (!was_full || pop);
    drop = we && was_full && !pop;
    if (pop) void'(mdl_q.pop_front());
    if (push) begin
      mdl_q.push_back(wd);
      mdl_mirror = wd;
    end
    if (drop) mdl_ovf = 1'b1;
    else if (clr) mdl_ovf = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Async reset pulse between edges, checked before the next edge.
  task automatic pulse_reset(input string tag);
    bus.write_enable   = 1'b0;
    bus.out_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
    #1 reset = 1'b1;
    mdl_q.delete();
    mdl_mirror = '0;
    mdl_ovf    = 1'b0;
    #1;
    check_all(tag);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.write_enable   = 1'b0;
    bus.write_data     = '0;
    bus.out_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
    mdl_mirror = '0;
    mdl_ovf    = 1'b0;
    @(posedge clk);
    #1;
    check_all("por");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset with three words queued.
    cycle(1'b1, 16'h0101, 1'b0, 1'b0, "t1w");
    cycle(1'b1, 16'h0202, 1'b0, 1'b0, "t1w");
    cycle(1'b1, 16'h0303, 1'b0, 1'b0, "t1w");
    pulse_reset("t1rst");
    chk("t1.level0", 32'(bus.level), 32'd0);

    // FWFT ordering.
    cycle(1'b1, 16'h1111, 1'b0, 1'b0, "t2w");
    cycle(1'b1, 16'h2222, 1'b0, 1'b0, "t2w");
    cycle(1'b1, 16'h3333, 1'b0, 1'b0, "t2w");
    chk("t2.head", 32'(bus.out_data), 32'h1111);
    chk("t2.mirror", 32'(bus.read_data), 32'h3333);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, "t2r");
    chk("t2.head2", 32'(bus.out_data), 32'h2222);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, "t2r");
    chk("t2.head3", 32'(bus.out_data), 32'h3333);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, "t2r");
    chk("t2.empty", 32'(bus.empty), 32'd1);

    // Overflow on the fifth write.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'hA0 + i), 1'b0, 1'b0, "t3w");
    chk("t3.full", 32'(bus.full), 32'd1);
    chk("t3.ovf", 32'(bus.overflow), 32'd1);
    chk("t3.mirror", 32'(bus.read_data), 32'h00A3);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, "t3clr");
    chk("t3.ovfclr", 32'(bus.overflow), 32'd0);

    // Full with simultaneous write and pop.
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, "t4pp");
    chk("t4.level", 32'(bus.level), 32'd4);
    chk("t4.ovf", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, "t4r");

    // Wrap-around with continuous write/ready.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'(i), 1'b1, 1'b0, "t5");
      chk("t5.lvl1", 32'(bus.level <= 1), 32'd1);
    end
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, "t5drain");

    // Drop and clear on the same edge: set wins.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'hC0 + i), 1'b0, 1'b0, "t6w");
    cycle(1'b1, 16'h00CF, 1'b0, 1'b1, "t6col");
    chk("t6.ovf", 32'(bus.overflow), 32'd1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b1, "t6clr");

    // Random traffic with occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      if ((n % 97) == 96) begin
        pulse_reset("rnd_rst");
      end else begin
        cycle($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 50,
              $urandom_range(0, 99) < 10, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
